// File: rtl/clint_timer.sv
// Core-local interruptor: machine timer, timer comparator and software-interrupt bit
// behind a single-outstanding valid/ready bus slave with 1-cycle response latency.
module clint_timer #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        timer_irq,
  output logic        soft_irq
);

  localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [12:0] OFF_MSIP     = 13'h0000;
  localparam logic [12:0] OFF_MTIMECMP = 13'h0800;
  localparam logic [12:0] OFF_MTIME    = 13'h17FF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_accept;

  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nxt;
  logic          w_tick;

  logic [63:0]   r_mtime;
  logic [63:0]   r_mtimecmp;
  logic          r_msip;
  logic [63:0]   w_mtime_inc;
  logic [63:0]   w_mtime_nxt;
  logic [63:0]   w_mtimecmp_nxt;
  logic          w_msip_nxt;

  logic          w_in_window;
  logic [12:0]   w_off;
  logic          w_sel_msip;
  logic          w_sel_mtimecmp;
  logic          w_sel_mtime;
  logic          w_err;
  logic          w_wr;
  logic [63:0]   w_rdata;
  logic          w_unused;

  logic          r_resp_valid;
  logic [63:0]   r_resp_rdata;
  logic          r_resp_err;

  // Replace the byte lanes selected by strb with the new value.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    res = old_v;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) begin
        res[i*8 +: 8] = new_v[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = old_v[i*8 +: 8];
      end
    end
    return res;
  endfunction

  assign w_unused       = ^req_addr[2:0];
  assign w_in_window    = (req_addr[63:16] == BASE_ADDR[63:16]);
  assign w_off          = req_addr[15:3];
  assign w_sel_msip     = w_in_window && (w_off == OFF_MSIP);
  assign w_sel_mtimecmp = w_in_window && (w_off == OFF_MTIMECMP);
  assign w_sel_mtime    = w_in_window && (w_off == OFF_MTIME);
  assign w_err          = !(w_sel_msip || w_sel_mtimecmp || w_sel_mtime);
  assign w_wr           = w_accept && req_we && !w_err;

  assign w_tick         = !halt && (r_presc == PRESC_MAX);
  assign w_mtime_inc    = r_mtime + {63'd0, w_tick};

  // Prescaler next value: frozen under halt, wraps on a tick.
  always_comb begin
    w_presc_nxt = r_presc;
    if (halt) begin
      w_presc_nxt = r_presc;
    end else if (w_tick) begin
      w_presc_nxt = '0;
    end else begin
      w_presc_nxt = r_presc + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  // Register next values; written lanes override the incremented mtime.
  always_comb begin
    w_mtime_nxt    = w_mtime_inc;
    w_mtimecmp_nxt = r_mtimecmp;
    w_msip_nxt     = r_msip;
    if (w_wr && w_sel_mtime) begin
      w_mtime_nxt = merge_bytes(w_mtime_inc, req_wdata, req_wstrb);
    end else begin
      w_mtime_nxt = w_mtime_inc;
    end
    if (w_wr && w_sel_mtimecmp) begin
      w_mtimecmp_nxt = merge_bytes(r_mtimecmp, req_wdata, req_wstrb);
    end else begin
      w_mtimecmp_nxt = r_mtimecmp;
    end
    if (w_wr && w_sel_msip && req_wstrb[0]) begin
      w_msip_nxt = req_wdata[0];
    end else begin
      w_msip_nxt = r_msip;
    end
  end

  // Read data from pre-update register values; writes and errors return zero.
  always_comb begin
    w_rdata = 64'd0;
    if (req_we || w_err) begin
      w_rdata = 64'd0;
    end else if (w_sel_msip) begin
      w_rdata = {63'd0, r_msip};
    end else if (w_sel_mtimecmp) begin
      w_rdata = r_mtimecmp;
    end else begin
      w_rdata = r_mtime;
    end
  end

  // Next-state logic and request accept.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, timer and register storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_presc    <= '0;
      r_mtime    <= 64'd0;
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_msip     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_presc    <= w_presc_nxt;
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_mtimecmp_nxt;
      r_msip     <= w_msip_nxt;
    end
  end

  // Response channel: captured on accept, held until the handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 64'd0;
      r_resp_err   <= 1'b0;
    end else if (w_accept) begin
      r_resp_valid <= 1'b1;
      r_resp_rdata <= w_rdata;
      r_resp_err   <= w_err;
    end else if ((r_state == ST_RESP) && resp_ready) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 64'd0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= r_resp_valid;
      r_resp_rdata <= r_resp_rdata;
      r_resp_err   <= r_resp_err;
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign timer_irq  = (r_mtime >= r_mtimecmp);
  assign soft_irq   = r_msip;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: one instance with TICK_DIV=1 and one with TICK_DIV=4
// share the bus inputs; expected values are hand-computed from cycle counts.
module tb_clint_timer;

  localparam logic [63:0] BASE     = 64'h0000_0000_0200_0000;
  localparam logic [63:0] A_MSIP   = BASE + 64'h0000;
  localparam logic [63:0] A_CMP    = BASE + 64'h4000;
  localparam logic [63:0] A_MTIME  = BASE + 64'hBFF8;
  localparam logic [63:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        halt       = 1'b0;
  logic        req_valid  = 1'b0;
  logic        req_we     = 1'b0;
  logic [63:0] req_addr   = 64'd0;
  logic [63:0] req_wdata  = 64'd0;
  logic [7:0]  req_wstrb  = 8'd0;
  logic        resp_ready = 1'b1;

  logic        ready1, valid1, err1, tirq1, sirq1;
  logic [63:0] rdata1;
  logic        ready4, valid4, err4, tirq4, sirq4;
  logic [63:0] rdata4;

  int n_cmp = 0;
  int n_mis = 0;

  logic [63:0] rd, rd4;
  logic        er;

  clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .req_valid(req_valid), .req_ready(ready1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(valid1), .resp_ready(resp_ready), .resp_rdata(rdata1),
    .resp_err(err1), .timer_irq(tirq1), .soft_irq(sirq1)
  );

  clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .req_valid(req_valid), .req_ready(ready4), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(valid4), .resp_ready(resp_ready), .resp_rdata(rdata4),
    .resp_err(err4), .timer_irq(tirq4), .soft_irq(sirq4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reset both instances; releases at a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    halt       = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One transaction, called at a falling edge; accept happens on the next rising edge
  // and the handshake on the one after, so it always spans exactly two rising edges.
  task automatic bus(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [7:0] strb, output logic [63:0] o_rd,
                     output logic o_err, output logic [63:0] o_rd4);
    check("req_ready_idle", 64'(ready1), 64'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    @(negedge clk);
    check("resp_valid", 64'(valid1), 64'd1);
    o_rd      = rdata1;
    o_err     = err1;
    o_rd4     = rdata4;
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset values of both instances
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_flags",
          64'({ready1, valid1, err1, tirq1, sirq1, ready4, valid4, err4, tirq4, sirq4}),
          64'({5'b10000, 5'b10000}));
    check("rst_rdata", rdata1 | rdata4, 64'd0);

    // Free-running mtime after 10 cycles
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    bus(1'b0, A_MTIME, 64'd0, 8'h00, rd, er, rd4);
    check("mtime_after_10", rd, 64'd10);
    check("mtime_rd_err", 64'(er), 64'd0);
    check("mtime4_after_10", rd4, 64'd2);
    check("tirq_idle", 64'(tirq1), 64'd0);

    // Comparator: written at mtime=5, irq rises when mtime reaches 20
    do_reset();
    repeat (5) @(negedge clk);
    bus(1'b1, A_CMP, 64'd20, 8'hFF, rd, er, rd4);
    repeat (12) @(negedge clk);
    check("tirq_at_19", 64'(tirq1), 64'd0);
    @(negedge clk);
    check("tirq_at_20", 64'(tirq1), 64'd1);
    bus(1'b1, A_CMP, ONES, 8'hFF, rd, er, rd4);
    check("tirq_cmp_max", 64'(tirq1), 64'd0);
    bus(1'b0, A_CMP, 64'd0, 8'h00, rd, er, rd4);
    check("cmp_readback", rd, ONES);

    // Software interrupt bit
    bus(1'b1, A_MSIP, ONES, 8'hFF, rd, er, rd4);
    check("sirq_set", 64'(sirq1), 64'd1);
    bus(1'b0, A_MSIP, 64'd0, 8'h00, rd, er, rd4);
    check("msip_read", rd, 64'd1);
    bus(1'b1, A_MSIP, 64'd0, 8'h00, rd, er, rd4);
    check("msip_nostrb_keep", 64'({sirq1, er}), 64'b10);
    bus(1'b1, A_MSIP, 64'd0, 8'hFF, rd, er, rd4);
    check("sirq_clear", 64'(sirq1), 64'd0);

    // Prescaler and halt: 6 running edges, 3 halted, then running again
    do_reset();
    repeat (6) @(negedge clk);
    halt = 1'b1;
    bus(1'b0, A_MTIME, 64'd0, 8'h00, rd, er, rd4);
    check("halt_mtime1", rd, 64'd6);
    check("halt_mtime4", rd4, 64'd1);
    @(negedge clk);
    halt = 1'b0;
    repeat (5) @(negedge clk);
    bus(1'b0, A_MTIME, 64'd0, 8'h00, rd, er, rd4);
    check("div4_at_11", rd4, 64'd2);
    check("div1_at_11", rd, 64'd11);
    bus(1'b0, A_MTIME, 64'd0, 8'h00, rd, er, rd4);
    check("div4_at_13", rd4, 64'd3);

    // Wrap at 2^64-1 and partial-strobe write merged with the increment
    do_reset();
    bus(1'b1, A_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, er, rd4);
    check("tirq_at_max", 64'(tirq1), 64'd1);
    @(negedge clk);
    check("tirq_after_wrap", 64'(tirq1), 64'd0);
    bus(1'b0, A_MTIME, 64'd0, 8'h00, rd, er, rd4);
    check("mtime_wrapped", rd, 64'd0);
    bus(1'b1, A_MTIME, 64'hAAAA_AAAA_0000_0000, 8'hF0, rd, er, rd4);
    bus(1'b0, A_MTIME, 64'd0, 8'h00, rd, er, rd4);
    check("mtime_partial", rd, 64'hAAAA_AAAA_0000_0004);

    // Errors, response hold under backpressure, reset during RESP
    do_reset();
    bus(1'b0, BASE + 64'h0008, 64'd0, 8'h00, rd, er, rd4);
    check("err_read", {er, rd[62:0]}, {1'b1, 63'd0});
    bus(1'b1, BASE + 64'h1_0000, ONES, 8'hFF, rd, er, rd4);
    check("err_window_wr", 64'({er, sirq1}), 64'b10);
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = A_MTIME;
    @(negedge clk);
    req_valid  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_flags", 64'({valid1, err1, ready1}), 64'b100);
      check("hold_rdata", rdata1, 64'd4);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_in_resp", 64'({valid1, ready1}), 64'b01);
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
